wdt_apb: RTL and testbench

//  APB-programmable watchdog timer; the source of rst_wdt_n for the SCU reset generator.
//  A down-counter reloads from LOAD and must be fed with a key write before it expires.

---
 rtl/wdt_apb.sv | 176 +++++++++++++++++
 tb/tb_wdt_apb.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_apb.sv
// APB watchdog timer.
// A down-counter is reloaded from LOAD and must be fed with a key write before it
// reaches zero. The first expiry raises the interrupt and reloads. A second expiry
// while the interrupt is still pending, with RSTEN set, emits a fixed-width
// active-low reset pulse on rst_wdt_n.
module wdt_apb #(
    parameter int          RST_PULSE  = 16,
    parameter logic [31:0] LOAD_RST   = 32'h0000_FFFF,
    parameter logic [31:0] FEED_KEY   = 32'h5A5A_A5A5,
    parameter logic [31:0] UNLOCK_KEY = 32'h1ACC_E551
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        wdt_int,
    output logic        rst_wdt_n
);

    localparam logic [7:0] ADDR_LOAD  = 8'h00;
    localparam logic [7:0] ADDR_VALUE = 8'h04;
    localparam logic [7:0] ADDR_CTRL  = 8'h08;
    localparam logic [7:0] ADDR_FEED  = 8'h0C;
    localparam logic [7:0] ADDR_STAT  = 8'h10;
    localparam logic [7:0] ADDR_LOCK  = 8'h14;

    localparam int PW = (RST_PULSE > 2) ? $clog2(RST_PULSE) : 1;
    localparam logic [PW-1:0] PCNT_START = PW'(RST_PULSE - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        PULSE
    } state_t;

    state_t        state_q;
    logic [31:0]   load_q;
    logic [31:0]   cnt_q;
    logic [PW-1:0] pcnt_q;
    logic          en_q;
    logic          rsten_q;
    logic          int_q;
    logic          locked_q;

    logic wr;
    logic rd;
    logic wr_load;
    logic wr_ctrl;
    logic feed_ok;
    logic w1c;
    logic en_rise;
    logic expire;
    logic int_set;
    logic pulse_go;
    logic int_clr;

    assign wr       = psel & penable & pwrite;
    assign rd       = psel & penable & ~pwrite;
    assign wr_load  = wr & (paddr == ADDR_LOAD) & ~locked_q;
    assign wr_ctrl  = wr & (paddr == ADDR_CTRL) & ~locked_q;
    assign feed_ok  = wr & (paddr == ADDR_FEED) & (pwdata == FEED_KEY);
    assign w1c      = wr & (paddr == ADDR_STAT) & pwdata[0];
    assign en_rise  = wr_ctrl & pwdata[0] & ~en_q;

    // A valid feed in the same cycle pre-empts the expiry entirely.
    assign expire   = (state_q == COUNT) & en_q & ~feed_ok & (cnt_q == 32'd0);
    assign int_set  = expire & ~int_q;
    assign pulse_go = expire & int_q & rsten_q;
    assign int_clr  = w1c | feed_ok | pulse_go;

    assign pready  = 1'b1;
    assign wdt_int = int_q;

    // Software-visible configuration: LOAD, CTRL and the lock bit.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            load_q   <= LOAD_RST;
            en_q     <= 1'b0;
            rsten_q  <= 1'b0;
            locked_q <= 1'b1;
        end else begin
            if (wr_load) begin
                load_q <= pwdata;
            end
            if (wr_ctrl) begin
                en_q    <= pwdata[0];
                rsten_q <= pwdata[1];
            end
            if (wr && (paddr == ADDR_LOCK)) begin
                locked_q <= (pwdata != UNLOCK_KEY);
            end
        end
    end

    // Interrupt flag: a new expiry wins over a simultaneous clear.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            int_q <= 1'b0;
        end else if (int_set) begin
            int_q <= 1'b1;
        end else if (int_clr) begin
            int_q <= 1'b0;
        end
    end

    // Watchdog sequencer: counting, reload on expiry/feed, and reset pulse timing.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= LOAD_RST;
            pcnt_q    <= '0;
            rst_wdt_n <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_rise) begin
                        cnt_q   <= load_q;
                        state_q <= COUNT;
                    end else if (feed_ok) begin
                        cnt_q <= load_q;
                    end
                end
                COUNT: begin
                    if (!en_q) begin
                        state_q <= IDLE;
                    end else if (feed_ok) begin
                        cnt_q <= load_q;
                    end else if (cnt_q == 32'd0) begin
                        if (int_q && rsten_q) begin
                            rst_wdt_n <= 1'b0;
                            pcnt_q    <= PCNT_START;
                            state_q   <= PULSE;
                        end else begin
                            cnt_q <= load_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                PULSE: begin
                    if (pcnt_q == '0) begin
                        rst_wdt_n <= 1'b1;
                        cnt_q     <= load_q;
                        state_q   <= en_q ? COUNT : IDLE;
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Combinational read mux; zero outside read access phases and for unmapped addresses.
    always_comb begin
        prdata = 32'd0;
        if (rd) begin
            case (paddr)
                ADDR_LOAD:  prdata = load_q;
                ADDR_VALUE: prdata = cnt_q;
                ADDR_CTRL:  prdata = {30'd0, rsten_q, en_q};
                ADDR_STAT:  prdata = {31'd0, int_q};
                ADDR_LOCK:  prdata = {31'd0, locked_q};
                default:    prdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_wdt_apb.sv
// Testbench for wdt_apb: directed scenarios followed by random APB traffic,
// checked against a cycle-level behavioural model through a scoreboard.
module tb_wdt_apb;

    localparam int          RST_PULSE  = 16;
    localparam logic [31:0] LOAD_RST   = 32'h0000_FFFF;
    localparam logic [31:0] FEED_KEY   = 32'h5A5A_A5A5;
    localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        wdt_int;
    logic        rst_wdt_n;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, in plain terms of the register map.
    logic [31:0] m_load;
    logic [31:0] m_cnt;
    logic        m_en;
    logic        m_rsten;
    logic        m_int;
    logic        m_locked;
    logic        m_counting;
    int          m_pulse_left;

    logic [31:0] read_q[$];
    logic [1:0]  out_q[$];

    wdt_apb #(
        .RST_PULSE (RST_PULSE),
        .LOAD_RST  (LOAD_RST),
        .FEED_KEY  (FEED_KEY),
        .UNLOCK_KEY(UNLOCK_KEY)
    ) dut (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .wdt_int  (wdt_int),
        .rst_wdt_n(rst_wdt_n)
    );

    always #5 pclk = ~pclk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load       = LOAD_RST;
        m_cnt        = LOAD_RST;
        m_en         = 1'b0;
        m_rsten      = 1'b0;
        m_int        = 1'b0;
        m_locked     = 1'b1;
        m_counting   = 1'b0;
        m_pulse_left = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return m_load;
            8'h04:   return m_cnt;
            8'h08:   return {30'd0, m_rsten, m_en};
            8'h10:   return {31'd0, m_int};
            8'h14:   return {31'd0, m_locked};
            default: return 32'd0;
        endcase
    endfunction

    // One clock of watchdog behaviour, using the bus values present this cycle.
    task automatic model_step();
        logic        wr;
        logic        feed;
        logic        w1c;
        logic        ctrl_ok;
        logic        set_int;
        logic        clr_int;
        logic [31:0] n_load;
        logic [31:0] n_cnt;
        logic        n_en;
        logic        n_rsten;
        logic        n_locked;
        logic        n_counting;
        int          n_pulse;
        wr      = psel && penable && pwrite;
        feed    = wr && paddr == 8'h0C && pwdata == FEED_KEY;
        w1c     = wr && paddr == 8'h10 && pwdata[0];
        ctrl_ok = wr && paddr == 8'h08 && !m_locked;
        set_int = 1'b0;
        clr_int = w1c || feed;
        n_load = m_load; n_cnt = m_cnt; n_en = m_en; n_rsten = m_rsten;
        n_locked = m_locked; n_counting = m_counting; n_pulse = m_pulse_left;
        if (wr && paddr == 8'h00 && !m_locked) n_load = pwdata;
        if (ctrl_ok) begin
            n_en    = pwdata[0];
            n_rsten = pwdata[1];
        end
        if (wr && paddr == 8'h14) n_locked = (pwdata != UNLOCK_KEY);
        if (m_pulse_left > 0) begin
            n_pulse = m_pulse_left - 1;
            if (n_pulse == 0) begin
                n_cnt      = m_load;
                n_counting = m_en;
            end
        end else if (!m_counting) begin
            if ((ctrl_ok && pwdata[0] && !m_en) || feed) n_cnt = m_load;
            if (ctrl_ok && pwdata[0] && !m_en) n_counting = 1'b1;
        end else if (!m_en) begin
            n_counting = 1'b0;
        end else if (feed) begin
            n_cnt = m_load;
        end else if (m_cnt == 0) begin
            if (!m_int) begin
                set_int = 1'b1;
                n_cnt   = m_load;
            end else if (m_rsten) begin
                n_pulse = RST_PULSE;
                clr_int = 1'b1;
            end else begin
                n_cnt = m_load;
            end
        end else begin
            n_cnt = m_cnt - 1;
        end
        if (set_int) m_int = 1'b1;
        else if (clr_int) m_int = 1'b0;
        m_load = n_load; m_cnt = n_cnt; m_en = n_en; m_rsten = n_rsten;
        m_locked = n_locked; m_counting = n_counting; m_pulse_left = n_pulse;
    endtask

    // Drive one bus cycle, queue the expected responses, then advance the model.
    task automatic apply_stimulus(input logic s, input logic en, input logic w,
                                  input logic [7:0] a, input logic [31:0] d);
        psel = s; penable = en; pwrite = w; paddr = a; pwdata = d;
        if (s && en && !w) read_q.push_back(model_read(a));
        out_q.push_back({m_int, (m_pulse_left == 0)});
        @(posedge pclk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        apply_stimulus(1'b1, 1'b0, 1'b1, a, d);
        apply_stimulus(1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic apb_read(input logic [7:0] a);
        apply_stimulus(1'b1, 1'b0, 1'b0, a, 32'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic read_all();
        apb_read(8'h00);
        apb_read(8'h04);
        apb_read(8'h08);
        apb_read(8'h0C);
        apb_read(8'h10);
        apb_read(8'h14);
    endtask

    // Monitor: compares queued expectations with what the DUT presents each cycle.
    always @(negedge pclk) begin
        logic [1:0]  exp_out;
        logic [31:0] exp_rd;
        if (out_q.size() > 0) begin
            exp_out = out_q.pop_front();
            check_output("wdt_int", {31'd0, wdt_int}, {31'd0, exp_out[1]});
            check_output("rst_wdt_n", {31'd0, rst_wdt_n}, {31'd0, exp_out[0]});
            check_output("pready", {31'd0, pready}, 32'd1);
        end
        if (psel && penable && !pwrite) begin
            if (read_q.size() == 0) begin
                check_output("read_queue_underflow", 32'd1, 32'd0);
            end else begin
                exp_rd = read_q.pop_front();
                check_output($sformatf("prdata@%02h", paddr), prdata, exp_rd);
            end
        end else begin
            check_output("prdata_idle", prdata, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int n;
        logic [7:0]  a;
        logic [31:0] d;
        int          op;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        rst_n = 1'b0;
        model_reset();
        @(posedge pclk);
        #1;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] reset values");
        read_all();

        $display("[TB] lock behaviour");
        apb_write(8'h08, 32'd3);
        apb_read(8'h08);
        apb_write(8'h14, UNLOCK_KEY);
        apb_write(8'h08, 32'd3);
        apb_read(8'h08);
        apb_write(8'h14, 32'd0);
        apb_write(8'h00, 32'h1234);
        apb_read(8'h00);
        apb_read(8'h14);

        $display("[TB] expiry and interrupt");
        apb_write(8'h14, UNLOCK_KEY);
        apb_write(8'h08, 32'd0);
        apb_write(8'h00, 32'd9);
        apb_write(8'h08, 32'd1);
        n = 0;
        while (!wdt_int && n < 50) begin
            idle(1);
            n++;
        end
        check_output("int_latency", n, 32'd10);
        apb_read(8'h04);
        apb_read(8'h10);
        apb_write(8'h10, 32'd1);
        apb_read(8'h10);

        $display("[TB] reset pulse");
        apb_write(8'h08, 32'd0);
        apb_write(8'h00, 32'd4);
        apb_write(8'h10, 32'd1);
        apb_write(8'h08, 32'd3);
        n = 0;
        while (rst_wdt_n && n < 100) begin
            idle(1);
            n++;
        end
        check_output("pulse_seen", {31'd0, rst_wdt_n}, 32'd0);
        n = 0;
        while (!rst_wdt_n && n < 100) begin
            idle(1);
            n++;
        end
        check_output("pulse_width", n, RST_PULSE);
        apb_read(8'h10);
        apb_read(8'h04);

        $display("[TB] feed");
        apb_write(8'h08, 32'd0);
        apb_write(8'h00, 32'd4);
        apb_write(8'h10, 32'd1);
        apb_write(8'h08, 32'd1);
        n = 0;
        while (m_cnt != 1 && n < 50) begin
            idle(1);
            n++;
        end
        check_output("feed_align", m_cnt, 32'd1);
        apb_write(8'h0C, FEED_KEY);
        check_output("feed_no_int", {31'd0, wdt_int}, 32'd0);
        apb_read(8'h04);
        apb_write(8'h0C, 32'h1234_5678);
        n = 0;
        while (!wdt_int && n < 50) begin
            idle(1);
            n++;
        end
        check_output("bad_feed_int", {31'd0, wdt_int}, 32'd1);

        $display("[TB] async reset during pulse");
        apb_write(8'h08, 32'd0);
        apb_write(8'h00, 32'd3);
        apb_write(8'h10, 32'd1);
        apb_write(8'h08, 32'd3);
        n = 0;
        while (m_pulse_left != RST_PULSE - 4 && n < 200) begin
            idle(1);
            n++;
        end
        check_output("pulse_cycle5_reached", m_pulse_left, RST_PULSE - 4);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("async_rst_wdt_n", {31'd0, rst_wdt_n}, 32'd1);
        check_output("async_wdt_int", {31'd0, wdt_int}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        read_all();

        $display("[TB] random traffic");
        apb_write(8'h14, UNLOCK_KEY);
        for (int i = 0; i < 1500; i++) begin
            op = $urandom_range(0, 9);
            if (op < 2) begin
                idle($urandom_range(1, 4));
            end else if (op < 4) begin
                a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 5) * 4);
                apb_read(a);
            end else begin
                case ($urandom_range(0, 6))
                    0: begin a = 8'h00; d = $urandom_range(0, 12); end
                    1: begin a = 8'h08; d = $urandom_range(0, 3); end
                    2: begin a = 8'h0C; d = ($urandom_range(0, 1) == 1) ? FEED_KEY : $urandom; end
                    3: begin a = 8'h10; d = $urandom; end
                    4: begin a = 8'h14; d = ($urandom_range(0, 3) != 0) ? UNLOCK_KEY : $urandom; end
                    5: begin a = 8'($urandom_range(0, 255)); d = $urandom; end
                    default: begin a = 8'h04; d = $urandom; end
                endcase
                apb_write(a, d);
            end
        end
        idle(3);
        check_output("read_queue_drained", read_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
